// File: rtl/wb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_pkg -- shared field widths and constants for wb_commit        rev 1.0
// ----------------------------------------------------------------------------
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Queue entry layout is {addr, data, pc}, most significant field first.
  function automatic int entry_w(input int data_w);
    return REG_ADDR_W + data_w + PC_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_fifo -- DEPTH-entry single-clock FIFO holding one write-back channel  rev 1.0
// ----------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when the same cycle pops: no pass-through.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_commit -- round-robin merge of N_CH write-back queues into one GRF port.
// Optional macro WB_COMMIT_TRACE_EN prints every committed write.   rev 1.0
// ----------------------------------------------------------------------------
module wb_commit
  import wb_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [REG_ADDR_W*N_CH-1:0] req_addr,
  input  logic [DATA_W*N_CH-1:0]   req_data,
  input  logic [PC_W*N_CH-1:0]     req_pc,
  output logic                     grf_we,
  output logic [REG_ADDR_W-1:0]    grf_addr,
  output logic [DATA_W-1:0]        grf_data,
  output logic [PC_W-1:0]          grf_pc,
  output logic                     drained
);

  localparam int ENT_W = entry_w(DATA_W);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [ENT_W-1:0] head [N_CH];
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  empty;
  logic [N_CH-1:0]  pop;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant;
  logic             any_valid;
  int               idx;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid[k]),
        .push_data ({req_addr[REG_ADDR_W*k +: REG_ADDR_W],
                     req_data[DATA_W*k +: DATA_W],
                     req_pc[PC_W*k +: PC_W]}),
        .pop       (pop[k]),
        .head      (head[k]),
        .full      (full[k]),
        .empty     (empty[k])
      );
      assign req_ready[k] = !full[k];
    end
  endgenerate

  // rr_ptr holds the highest-priority channel for the current cycle.
  always_comb begin
    grant     = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(rr_ptr) + i) % N_CH;
      if (!any_valid && !empty[idx]) begin
        any_valid = 1'b1;
        grant     = CH_W'(idx);
      end
    end
    pop = any_valid ? (N_CH'(1) << grant) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      grf_we   <= 1'b0;
      grf_addr <= '0;
      grf_data <= '0;
      grf_pc   <= '0;
    end else if (any_valid) begin
      rr_ptr <= (int'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
      {grf_addr, grf_data, grf_pc} <= head[grant];
      grf_we <= (head[grant][ENT_W-1 -: REG_ADDR_W] != ZERO_REG);
    end else begin
      grf_we <= 1'b0;
    end
  end

  assign drained = (&empty) && !grf_we;

`ifdef WB_COMMIT_TRACE_EN
  always @(posedge clk) begin
    if (grf_we) $display("@%08h: $%02d <= %08h", grf_pc, grf_addr, grf_data);
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// tb_wb_commit -- scoreboard bench: 2ch/DEPTH2 instance for directed cases,
// 4ch/DEPTH4 instance for a random-traffic soak.
module tb_wb_commit;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exp_we;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]   valid2, ready2;
  logic [9:0]   addr2;
  logic [63:0]  data2, pc2;
  logic         we2, drained2;
  logic [4:0]   gaddr2;
  logic [31:0]  gdata2, gpc2;

  logic [3:0]   valid4, ready4;
  logic [19:0]  addr4;
  logic [127:0] data4, pc4;
  logic         we4, drained4;
  logic [4:0]   gaddr4;
  logic [31:0]  gdata4, gpc4;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int commits2 = 0, commits4 = 0, acc2 = 0, acc4 = 0;
  ent_t q2 [2][$];
  ent_t q4 [4][$];
  int log_ch [$];
  int log_cyc [$];
  logic r0hist [8];

  wb_commit #(.N_CH(2), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
    .req_addr(addr2), .req_data(data2), .req_pc(pc2),
    .grf_we(we2), .grf_addr(gaddr2), .grf_data(gdata2), .grf_pc(gpc2),
    .drained(drained2));

  wb_commit #(.N_CH(4), .DATA_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(valid4), .req_ready(ready4),
    .req_addr(addr4), .req_data(data4), .req_pc(pc4),
    .grf_we(we4), .grf_addr(gaddr4), .grf_data(gdata4), .grf_pc(gpc4),
    .drained(drained4));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    total++;
    $display("FAIL %s: got %0h, required no such commit", name, act);
  endtask

  // Commit monitors: the producing channel is tagged in pc[31:28].
  always @(negedge clk) begin : mon2
    int ch;
    ent_t e;
    if (we2 === 1'b1) begin
      ch = int'(gpc2[31:28]);
      if (ch > 1 || q2[ch].size() == 0) begin
        fail("commit2_unexpected", {gaddr2, gdata2, gpc2});
      end else begin
        e = q2[ch].pop_front();
        check("commit2", {gaddr2, gdata2, gpc2}, e);
        commits2++;
        log_ch.push_back(ch);
        log_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : mon4
    int ch;
    ent_t e;
    if (we4 === 1'b1) begin
      ch = int'(gpc4[31:28]);
      if (ch > 3 || q4[ch].size() == 0) begin
        fail("commit4_unexpected", {gaddr4, gdata4, gpc4});
      end else begin
        e = q4[ch].pop_front();
        check("commit4", {gaddr4, gdata4, gpc4}, e);
        commits4++;
      end
    end
  end

  // Drives n0/n1 requests on the 2-channel instance, holding each until accepted.
  task automatic run2(input int n0, input int n1, input int tag);
    int sent [2];
    int nreq [2];
    ent_t e [2];
    int c;
    sent[0] = 0; sent[1] = 0; nreq[0] = n0; nreq[1] = n1; c = 0;
    while ((sent[0] < n0 || sent[1] < n1) && c < 60) begin
      for (int k = 0; k < 2; k++) begin
        e[k].addr = 5'(1 + k * 8 + sent[k]);
        e[k].data = 32'(tag * 256 + k * 16 + sent[k]);
        e[k].pc   = {4'(k), 28'(tag * 256 + sent[k])};
        valid2[k] = (sent[k] < nreq[k]);
        addr2[5*k +: 5]  = e[k].addr;
        data2[32*k +: 32] = e[k].data;
        pc2[32*k +: 32]   = e[k].pc;
      end
      @(negedge clk);
      if (c < 8) r0hist[c] = ready2[0];
      for (int k = 0; k < 2; k++) begin
        if (valid2[k] && ready2[k]) begin
          q2[k].push_back(e[k]);
          sent[k]++;
          acc2++;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    check("run2_all_accepted", (c < 60), 1'b1);
    valid2 = 2'b00;
  endtask

  task automatic wait_drain2(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!drained2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, drained2, 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) q2[k].delete();
    for (int k = 0; k < 4; k++) q4[k].delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tv [4];
    ent_t cur [4];
    ent_t e;
    logic [3:0] hold;
    int seq, c0, a0;

    reset = 1'b1;
    valid2 = '0; addr2 = '0; data2 = '0; pc2 = '0;
    valid4 = '0; addr4 = '0; data4 = '0; pc4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_we", we2, 1'b0);
    check("rst_addr", gaddr2, 5'd0);
    check("rst_data", gdata2, 32'd0);
    check("rst_pc", gpc2, 32'd0);
    check("rst_ready", ready2, 2'b11);
    check("rst_drained", drained2, 1'b1);
    check("rst_ready4", ready4, 4'hf);
    check("rst_drained4", drained4, 1'b1);
    @(posedge clk); #1;

    // Both channels streaming from reset: strict ch0,ch1 alternation.
    log_ch.delete(); log_cyc.delete();
    run2(4, 4, 1);
    wait_drain2("alt_drain");
    check("alt_count", log_ch.size(), 8);
    for (int i = 0; i < 8 && i < log_ch.size(); i++) begin
      check($sformatf("alt_ch%0d", i), log_ch[i], i % 2);
      if (i > 0) check($sformatf("alt_gap%0d", i), log_cyc[i] - log_cyc[i-1], 1);
    end
    @(posedge clk); #1;

    // Single ch0 requests: two-edge latency and the $0 suppression.
    tv[0] = '{5'd5,  32'h0000_1234, 32'h0000_3000, 1'b1};
    tv[1] = '{5'd0,  32'h0000_FFFF, 32'h0000_3004, 1'b0};
    tv[2] = '{5'd31, 32'hDEAD_BEEF, 32'h0000_3008, 1'b1};
    tv[3] = '{5'd1,  32'h0000_0000, 32'h0000_300C, 1'b1};
    for (int i = 0; i < 4; i++) begin
      valid2 = 2'b01;
      addr2  = {5'd0, tv[i].addr};
      data2  = {32'd0, tv[i].data};
      pc2    = {32'd0, tv[i].pc};
      @(negedge clk);
      check($sformatf("tv%0d_ready", i), ready2[0], 1'b1);
      if (tv[i].addr != 5'd0) begin
        e.addr = tv[i].addr; e.data = tv[i].data; e.pc = tv[i].pc;
        q2[0].push_back(e);
      end
      @(posedge clk); #1;
      valid2 = 2'b00;
      @(negedge clk);
      check($sformatf("tv%0d_we_edge1", i), we2, 1'b0);
      @(negedge clk);
      check($sformatf("tv%0d_we", i), we2, tv[i].exp_we);
      check($sformatf("tv%0d_addr", i), gaddr2, tv[i].addr);
      check($sformatf("tv%0d_data", i), gdata2, tv[i].data);
      check($sformatf("tv%0d_pc", i), gpc2, tv[i].pc);
      @(negedge clk);
      check($sformatf("tv%0d_we_after", i), we2, 1'b0);
      check($sformatf("tv%0d_drained", i), drained2, 1'b1);
      @(posedge clk); #1;
    end

    // ch0 fills up while ch1 competes: ready drops after two unpopped entries.
    pulse_reset();
    a0 = acc2; c0 = commits2;
    run2(3, 3, 2);
    check("fill_ready0_e2", r0hist[2], 1'b1);
    check("fill_ready0_e3", r0hist[3], 1'b0);
    wait_drain2("fill_drain");
    check("fill_q0_empty", q2[0].size(), 0);
    check("fill_q1_empty", q2[1].size(), 0);
    check("fill_no_loss", commits2 - c0, acc2 - a0);
    @(posedge clk); #1;

    // Mid-operation reset discards everything queued.
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        addr2[5*k +: 5]   = 5'(3 + k + 2 * c);
        data2[32*k +: 32] = 32'(32'h300 + k * 16 + c);
        pc2[32*k +: 32]   = {4'(k), 28'(32'h300 + c)};
      end
      valid2 = 2'b11;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (ready2[k]) begin
          e.addr = addr2[5*k +: 5]; e.data = data2[32*k +: 32]; e.pc = pc2[32*k +: 32];
          q2[k].push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    valid2 = 2'b00;
    reset  = 1'b1;
    @(negedge clk);
    check("mid_busy", drained2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    q2[0].delete(); q2[1].delete();
    c0 = commits2;
    @(negedge clk);
    check("mid_we", we2, 1'b0);
    check("mid_addr", gaddr2, 5'd0);
    check("mid_data", gdata2, 32'd0);
    check("mid_pc", gpc2, 32'd0);
    check("mid_ready", ready2, 2'b11);
    check("mid_drained", drained2, 1'b1);
    repeat (6) @(negedge clk);
    check("mid_no_commit", commits2 - c0, 0);
    check("mid_still_drained", drained2, 1'b1);
    @(posedge clk); #1;

    // Random soak on the 4-channel, 4-deep instance.
    pulse_reset();
    hold = 4'b0000; seq = 0; a0 = acc4; c0 = commits4;
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (!hold[k]) begin
          valid4[k]   = 1'($urandom_range(0, 1));
          cur[k].addr = 5'($urandom_range(1, 31));
          cur[k].data = $urandom;
          cur[k].pc   = {4'(k), 28'(seq)};
          seq++;
        end
        addr4[5*k +: 5]   = cur[k].addr;
        data4[32*k +: 32] = cur[k].data;
        pc4[32*k +: 32]   = cur[k].pc;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (valid4[k] && ready4[k]) begin
          q4[k].push_back(cur[k]);
          acc4++;
          hold[k] = 1'b0;
        end else begin
          hold[k] = valid4[k];
        end
      end
      @(posedge clk); #1;
    end
    valid4 = 4'b0000;
    for (int n = 0; n < 60 && !(drained4 === 1'b1); n++) @(negedge clk);
    @(negedge clk);
    check("rand_drained", drained4, 1'b1);
    for (int k = 0; k < 4; k++) check($sformatf("rand_q%0d_empty", k), q4[k].size(), 0);
    check("rand_commit_count", commits4 - c0, acc4 - a0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
